// File: rtl/gromitsys_sb_lock_rst_seq.sv
// rtl/gromitsys_sb_lock_rst_seq.sv - CCC lock qualifier and two-stage fabric reset sequencer on GL0
// Optional lock-acquire timeout flag built when GROMIT_LOCK_TIMEOUT_EN is defined.
module gromitsys_sb_lock_rst_seq #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int LOSS_FILTER    = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       GL0,
  input  logic       POWER_ON_RESET_N,
  input  logic       LOCK,
  input  logic       CLR_LOSS,
  output logic       FAB_RESET_N,
  output logic       PERIPH_RESET_N,
  output logic       READY,
  output logic [7:0] LOCK_LOSS_CNT,
  output logic       TIMEOUT
);

  localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] S_STABLE     = 3'd1;
  localparam logic [2:0] S_REL_FAB    = 3'd2;
  localparam logic [2:0] S_REL_PERIPH = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;
  localparam logic [2:0] S_LOST       = 3'd5;

  if (STABLE_CYCLES < 2 || STAGE_GAP < 1 || LOSS_FILTER < 1 ||
      longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(STAGE_GAP) >= (longint'(1) << CNT_W) ||
      longint'(LOSS_FILTER) >= (longint'(1) << CNT_W) ||
      longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("gromitsys_sb_lock_rst_seq: illegal parameter combination");
  end

  logic             sync1_q, lock_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic             fab_q, fab_d;
  logic             periph_q, periph_d;
  logic             ready_q, ready_d;
  logic [7:0]       loss_q, loss_d;
  logic             loss_hit;
  logic             released;

  assign released = (state_q == S_REL_FAB) || (state_q == S_REL_PERIPH) || (state_q == S_RUN);
  assign loss_hit = released && !lock_s_q && (filt_q == CNT_W'(LOSS_FILTER - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    fab_d    = fab_q;
    periph_d = periph_q;
    ready_d  = ready_q;
    loss_d   = loss_q;

    if (released) begin
      filt_d = lock_s_q ? '0 : filt_q + 1'b1;
    end

    case (state_q)
      S_WAIT_LOCK: begin
        fab_d    = 1'b0;
        periph_d = 1'b0;
        ready_d  = 1'b0;
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      // Any dropout before the first release restarts qualification from scratch.
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_REL_FAB;
          cnt_d   = '0;
          filt_d  = '0;
          fab_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REL_FAB: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          state_d  = S_REL_PERIPH;
          periph_d = 1'b1;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REL_PERIPH: state_d = S_RUN;
      S_RUN:        state_d = S_RUN;
      S_LOST: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d  = S_WAIT_LOCK;
        cnt_d    = '0;
        fab_d    = 1'b0;
        periph_d = 1'b0;
        ready_d  = 1'b0;
      end
    endcase

    if (loss_hit) begin
      state_d  = S_LOST;
      cnt_d    = '0;
      filt_d   = '0;
      fab_d    = 1'b0;
      periph_d = 1'b0;
      ready_d  = 1'b0;
    end

    // A clear coinciding with a loss event still records that event.
    if (CLR_LOSS) begin
      loss_d = loss_hit ? 8'd1 : 8'd0;
    end else if (loss_hit && loss_q != 8'hFF) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge GL0) begin
    if (!POWER_ON_RESET_N) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      state_q  <= S_WAIT_LOCK;
      cnt_q    <= '0;
      filt_q   <= '0;
      fab_q    <= 1'b0;
      periph_q <= 1'b0;
      ready_q  <= 1'b0;
      loss_q   <= 8'd0;
    end else begin
      sync1_q  <= LOCK;
      lock_s_q <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      fab_q    <= fab_d;
      periph_q <= periph_d;
      ready_q  <= ready_d;
      loss_q   <= loss_d;
    end
  end

`ifdef GROMIT_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
      if (wait_q != CNT_W'(TIMEOUT_CYCLES)) begin
        wait_d = wait_q + 1'b1;
      end
      if (wait_d == CNT_W'(TIMEOUT_CYCLES)) begin
        timeout_d = 1'b1;
      end
    end
    if (state_d == S_REL_FAB && state_q != S_REL_FAB) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge GL0) begin
    if (!POWER_ON_RESET_N) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign FAB_RESET_N    = fab_q;
  assign PERIPH_RESET_N = periph_q;
  assign READY          = ready_q;
  assign LOCK_LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_gromitsys_sb_lock_rst_seq.sv
// tb/tb_gromitsys_sb_lock_rst_seq.sv - randomized bench with event-level reference model
module tb_gromitsys_sb_lock_rst_seq;

  localparam int STABLE = 8;
  localparam int GAP    = 4;
  localparam int LOSS   = 3;
  localparam int TMO    = 50;

  logic       GL0 = 1'b0;
  logic       POWER_ON_RESET_N = 1'b0;
  logic       LOCK = 1'b0;
  logic       CLR_LOSS = 1'b0;
  logic       FAB_RESET_N, PERIPH_RESET_N, READY, TIMEOUT;
  logic [7:0] LOCK_LOSS_CNT;

  int checks = 0;
  int errors = 0;

  gromitsys_sb_lock_rst_seq #(
    .STABLE_CYCLES(STABLE), .STAGE_GAP(GAP), .LOSS_FILTER(LOSS),
    .CNT_W(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .GL0(GL0), .POWER_ON_RESET_N(POWER_ON_RESET_N), .LOCK(LOCK), .CLR_LOSS(CLR_LOSS),
    .FAB_RESET_N(FAB_RESET_N), .PERIPH_RESET_N(PERIPH_RESET_N), .READY(READY),
    .LOCK_LOSS_CNT(LOCK_LOSS_CNT), .TIMEOUT(TIMEOUT)
  );

  always #5 GL0 = ~GL0;

  // Reference model: lock history, qualification run length, time since release.
  bit m_s1, m_s2, m_up, m_lost;
  int m_qual, m_since, m_zeros, m_cnt, m_wait;
  bit m_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_up = 0; m_lost = 0;
    m_qual = 0; m_since = 0; m_zeros = 0; m_cnt = 0; m_wait = 0; m_tmo = 0;
  endtask

  task automatic model_edge(input bit lk, input bit clr);
    bit ls, inc;
    ls = m_s2;
    inc = 0;
    m_s2 = m_s1;
    m_s1 = lk;
    if (!m_up) begin
      if (m_lost) begin
        m_lost = 0;
        m_qual = 0;
      end else begin
        if (m_wait < TMO) m_wait++;
        if (m_wait >= TMO) m_tmo = 1;
        if (ls) begin
          m_qual++;
          if (m_qual == STABLE) begin
            m_up = 1; m_since = 0; m_zeros = 0; m_qual = 0; m_wait = 0;
          end
        end else begin
          m_qual = 0;
        end
      end
    end else begin
      m_since++;
      m_zeros = ls ? 0 : m_zeros + 1;
      if (m_zeros == LOSS) begin
        m_up = 0; m_lost = 1; m_zeros = 0; inc = 1;
      end
    end
    if (clr) m_cnt = inc ? 1 : 0;
    else if (inc && m_cnt < 255) m_cnt++;
  endtask

  function automatic bit exp_timeout();
`ifdef GROMIT_LOCK_TIMEOUT_EN
    return m_tmo;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    bit p;
    p = m_up && (m_since >= GAP);
    check("fab", FAB_RESET_N, m_up);
    check("periph", PERIPH_RESET_N, p);
    check("ready", READY, p);
    check("loss_cnt", LOCK_LOSS_CNT, m_cnt);
    check("timeout", TIMEOUT, exp_timeout());
  endtask

  task automatic step(input bit lk, input bit clr);
    LOCK = lk;
    CLR_LOSS = clr;
    @(posedge GL0);
    model_edge(lk, clr);
    #1;
    compare_all();
    CLR_LOSS = 0;
  endtask

  task automatic do_reset(input bit lk);
    POWER_ON_RESET_N = 0;
    LOCK = lk;
    CLR_LOSS = 0;
    @(posedge GL0);
    model_reset();
    #1;
    check("rst_fab", FAB_RESET_N, 1'b0);
    check("rst_periph", PERIPH_RESET_N, 1'b0);
    check("rst_ready", READY, 1'b0);
    check("rst_cnt", LOCK_LOSS_CNT, 8'd0);
    check("rst_timeout", TIMEOUT, 1'b0);
    POWER_ON_RESET_N = 1;
  endtask

  task automatic run_s1();
    do_reset(1'b1);
    for (int e = 1; e <= 16; e++) begin
      step(1'b1, 1'b0);
      if (e == 9)  check("s1_fab_e9", FAB_RESET_N, 1'b0);
      if (e == 10) check("s1_fab_e10", FAB_RESET_N, 1'b1);
      if (e == 13) check("s1_periph_e13", PERIPH_RESET_N, 1'b0);
      if (e == 14) begin
        check("s1_periph_e14", PERIPH_RESET_N, 1'b1);
        check("s1_ready_e14", READY, 1'b1);
      end
    end
  endtask

  initial begin
    bit lk, found;
    int seg;

    run_s1();

    // Dropout sampled at edge 6 during qualification.
    do_reset(1'b1);
    for (int e = 1; e <= 18; e++) begin
      step(e != 6, 1'b0);
      if (e == 15) check("s2_fab_e15", FAB_RESET_N, 1'b0);
      if (e == 16) check("s2_fab_e16", FAB_RESET_N, 1'b1);
    end

    // Loss filter in RUN.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("s3_short_ready", READY, 1'b1);
    check("s3_short_cnt", LOCK_LOSS_CNT, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("s3_lost_fab", FAB_RESET_N, 1'b0);
    check("s3_lost_ready", READY, 1'b0);
    check("s3_lost_cnt", LOCK_LOSS_CNT, 8'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("s3_rerun_ready", READY, 1'b1);

    // Reset while in REL_FAB, then scenario 1 again.
    do_reset(1'b1);
    for (int e = 1; e <= 11; e++) step(1'b1, 1'b0);
    check("s5_relfab_fab", FAB_RESET_N, 1'b1);
    check("s5_relfab_periph", PERIPH_RESET_N, 1'b0);
    run_s1();

    // Saturation and clear behaviour of the loss counter.
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 16; j++) step(1'b1, 1'b0);
      for (int j = 0; j < 5; j++) step(1'b0, 1'b0);
    end
    check("s4_sat", LOCK_LOSS_CNT, 8'd255);
    step(1'b0, 1'b1);
    check("s4_clr", LOCK_LOSS_CNT, 8'd0);
    for (int j = 0; j < 16; j++) step(1'b1, 1'b0);
    found = 0;
    for (int j = 0; j < 40 && !found; j++) begin
      if (m_up && !m_s2 && m_zeros == LOSS - 1) begin
        step(1'b0, 1'b1);
        check("s4_clr_inc", LOCK_LOSS_CNT, 8'd1);
        found = 1;
      end else begin
        step(1'b0, 1'b0);
      end
    end
    if (!found) check("s4_align", 32'd0, 32'd1);

    // Lock-acquire timeout.
    do_reset(1'b0);
    for (int i = 0; i < 55; i++) step(1'b0, 1'b0);
`ifdef GROMIT_LOCK_TIMEOUT_EN
    check("s6_tmo", TIMEOUT, 1'b1);
`else
    check("s6_tmo", TIMEOUT, 1'b0);
`endif
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("s6_tmo_sticky", TIMEOUT, exp_timeout());

    // Randomized segments of lock/no-lock with sporadic clears and resets.
    lk = 1;
    for (int i = 0; i < 200; i++) begin
      seg = lk ? $urandom_range(1, 30) : $urandom_range(1, 5);
      for (int j = 0; j < seg; j++) step(lk, ($urandom_range(0, 49) == 0));
      lk = !lk;
      if ($urandom_range(0, 59) == 0) do_reset(lk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
